// File: rtl/mems_mics_capture_ctrl_pkg.sv
// Shared definitions for the MEMS microphone capture controller:
// capture state encoding, default buffer address width and sample width.
package mems_mics_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cap_state_t;

  // Default byte-addressed capture buffer: 2^12 = 4096 samples.
  localparam int DEF_ADDR_W = 12;

  // Every microphone channel delivers 8-bit samples.
  localparam int SAMPLE_W = 8;

  // Largest number of microphone requesters the arbiter is sized for.
  localparam int MAX_CH = 8;

endpackage

// File: rtl/mems_mics_capture_ctrl_if.sv
// Microphone handshake plus RAM port-2 write bus of the capture controller.
// master: the capture controller (grants samples, drives the RAM port).
// slave : the microphone front ends and the RAM.
interface mems_mics_capture_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = mems_mics_pkg::DEF_ADDR_W
);
  import mems_mics_pkg::*;

  logic [NUM_CH-1:0]          mic_valid;
  logic [NUM_CH*SAMPLE_W-1:0] mic_data;
  logic [NUM_CH-1:0]          mic_ready;
  logic [ADDR_W-1:0]          ram_address2;
  logic                       ram_chipselect2;
  logic                       ram_write2;
  logic                       ram_clken2;
  logic [SAMPLE_W-1:0]        ram_writedata2;

  modport master (
    input  mic_valid,
    input  mic_data,
    output mic_ready,
    output ram_address2,
    output ram_chipselect2,
    output ram_write2,
    output ram_clken2,
    output ram_writedata2
  );

  modport slave (
    output mic_valid,
    output mic_data,
    input  mic_ready,
    input  ram_address2,
    input  ram_chipselect2,
    input  ram_write2,
    input  ram_clken2,
    input  ram_writedata2
  );

endinterface

// File: rtl/mems_mics_capture_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requesting channel found
// when searching upward (with wrap) from the channel after the last one
// accepted. The search pointer only moves when a grant is accepted.
module mems_mics_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              accept,
  output logic [NUM_CH-1:0] grant
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant_idx;
  logic             found;
  int               idx;

  // Rotating priority search starting at ptr
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && req[IDX_W'(idx)]) begin
        found                = 1'b1;
        grant[IDX_W'(idx)]   = 1'b1;
        grant_idx            = IDX_W'(idx);
      end
    end
  end

  // Move the search start just past the accepted channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/mems_mics_capture_ctrl.sv
// MEMS microphone capture controller: arbitrates NUM_CH 8-bit sample
// streams into a byte RAM through port 2, one sample per cycle, with
// half/full interrupt flags and a sticky overrun indicator.
// CONTINUOUS=1 wraps around the buffer; CONTINUOUS=0 stops (DONE) after
// the last address has been written.
// Optional build macro MEMS_MICS_OVERRUN_CNT_EN adds a saturating 16-bit
// overrun event counter output (overrun_cnt).
module mems_mics_capture_ctrl
  import mems_mics_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int CONTINUOUS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  mems_mics_capture_ctrl_if.master bus,
  output logic [ADDR_W-1:0]        wr_ptr,
  output logic                     irq_half,
  output logic                     irq_full,
  input  logic                     irq_ack,
  output logic                     overrun
`ifdef MEMS_MICS_OVERRUN_CNT_EN
  ,
  output logic [15:0]              overrun_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] HALF_ADDR = LAST_ADDR >> 1;

  cap_state_t          state;
  logic                active;
  logic                start_run;
  logic [NUM_CH-1:0]   req;
  logic [NUM_CH-1:0]   grant;
  logic                xfer;
  logic                last_xfer;
  logic [SAMPLE_W-1:0] sel_data;

  logic                wr_en_r;
  logic                cs_r;
  logic                clken_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [SAMPLE_W-1:0] wdata_r;

  logic                half_hit;
  logic                full_hit;

  logic [NUM_CH-1:0]   denied;
  logic [NUM_CH-1:0]   denied_prev;
  logic [NUM_CH-1:0]   ov_hit;
  logic                ov_event;

  // Grants are only offered while running and still enabled, so a falling
  // enable never starts a new transfer.
  assign active    = (state == RUN) && enable;
  assign start_run = (state == IDLE) && enable;
  assign req       = bus.mic_valid & {NUM_CH{active}};
  assign xfer      = |grant;
  assign last_xfer = xfer && (wr_ptr == LAST_ADDR);

  mems_mics_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk    (clk),
    .rst    (reset),
    .req    (req),
    .accept (xfer),
    .grant  (grant)
  );

  // Select the granted channel's sample
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant[k]) sel_data = bus.mic_data[SAMPLE_W*k +: SAMPLE_W];
    end
  end

  assign bus.mic_ready       = grant;
  assign bus.ram_write2      = wr_en_r;
  assign bus.ram_chipselect2 = cs_r;
  assign bus.ram_clken2      = clken_r;
  assign bus.ram_address2    = addr_r;
  assign bus.ram_writedata2  = wdata_r;

  // Capture FSM with the registered RAM port-2 write stage and write pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      wr_en_r <= 1'b0;
      cs_r    <= 1'b0;
      clken_r <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else begin
      clken_r <= 1'b1;
      wr_en_r <= xfer;
      cs_r    <= xfer;
      if (xfer) begin
        addr_r  <= wr_ptr;
        wdata_r <= sel_data;
        wr_ptr  <= wr_ptr + ADDR_W'(1);
      end
      case (state)
        IDLE: begin
          if (enable) begin
            state  <= RUN;
            wr_ptr <= '0;
          end
        end
        RUN: begin
          if (!enable) state <= IDLE;
          else if (last_xfer && (CONTINUOUS == 0)) state <= DONE;
        end
        DONE: begin
          if (!enable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flags set on the cycle the RAM write is presented; set beats an ack
  assign half_hit = wr_en_r && (addr_r == HALF_ADDR);
  assign full_hit = wr_en_r && (addr_r == LAST_ADDR);

  // Sticky half/full interrupt flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_half <= 1'b0;
      irq_full <= 1'b0;
    end else begin
      if (half_hit)     irq_half <= 1'b1;
      else if (irq_ack) irq_half <= 1'b0;
      if (full_hit)     irq_full <= 1'b1;
      else if (irq_ack) irq_full <= 1'b0;
    end
  end

  // A channel is denied when it asks during an arbitration cycle and loses.
  // Two denials in a row form one overrun event; the streak then restarts.
  assign denied   = bus.mic_valid & ~grant & {NUM_CH{active}};
  assign ov_hit   = denied & denied_prev;
  assign ov_event = |ov_hit;

  // Per-channel denial streak tracking and sticky overrun flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      denied_prev <= '0;
      overrun     <= 1'b0;
    end else if (start_run) begin
      denied_prev <= '0;
      overrun     <= 1'b0;
    end else begin
      denied_prev <= denied & ~ov_hit;
      if (ov_event) overrun <= 1'b1;
    end
  end

`ifdef MEMS_MICS_OVERRUN_CNT_EN
  // Saturating count of overrun events since the last run start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_cnt <= '0;
    end else if (start_run) begin
      overrun_cnt <= '0;
    end else if (ov_event && (overrun_cnt != 16'hFFFF)) begin
      overrun_cnt <= overrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mems_mics_capture_ctrl.sv
// Bench for mems_mics_capture_ctrl: a wrapping (CONTINUOUS=1) and a
// one-shot (CONTINUOUS=0) instance share the same stimulus and are compared
// every cycle against a behavioural buffer model.
module tb_mems_mics_capture_ctrl;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic                  cur_en   = 1'b0;
  logic                  cur_ack  = 1'b0;
  logic [NUM_CH-1:0]     cur_v    = '0;
  logic [NUM_CH*8-1:0]   cur_data = '0;

  always #5 clk = ~clk;

  mems_mics_capture_ctrl_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus0();
  mems_mics_capture_ctrl_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus1();

  assign bus0.mic_valid = cur_v;
  assign bus1.mic_valid = cur_v;
  assign bus0.mic_data  = cur_data;
  assign bus1.mic_data  = cur_data;

  logic [NUM_CH-1:0] o_ready [2];
  logic              o_wr    [2];
  logic              o_cs    [2];
  logic              o_ck    [2];
  logic [ADDR_W-1:0] o_addr  [2];
  logic [7:0]        o_data  [2];
  logic [ADDR_W-1:0] o_wp    [2];
  logic              o_half  [2];
  logic              o_full  [2];
  logic              o_ov    [2];
`ifdef MEMS_MICS_OVERRUN_CNT_EN
  logic [15:0]       o_cnt   [2];
`endif

  assign o_ready[0] = bus0.mic_ready;       assign o_ready[1] = bus1.mic_ready;
  assign o_wr[0]    = bus0.ram_write2;      assign o_wr[1]    = bus1.ram_write2;
  assign o_cs[0]    = bus0.ram_chipselect2; assign o_cs[1]    = bus1.ram_chipselect2;
  assign o_ck[0]    = bus0.ram_clken2;      assign o_ck[1]    = bus1.ram_clken2;
  assign o_addr[0]  = bus0.ram_address2;    assign o_addr[1]  = bus1.ram_address2;
  assign o_data[0]  = bus0.ram_writedata2;  assign o_data[1]  = bus1.ram_writedata2;

  mems_mics_capture_ctrl #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CONTINUOUS(1)) dut0 (
    .clk(clk), .reset(reset), .enable(cur_en), .bus(bus0),
    .wr_ptr(o_wp[0]), .irq_half(o_half[0]), .irq_full(o_full[0]),
    .irq_ack(cur_ack), .overrun(o_ov[0])
`ifdef MEMS_MICS_OVERRUN_CNT_EN
    , .overrun_cnt(o_cnt[0])
`endif
  );

  mems_mics_capture_ctrl #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CONTINUOUS(0)) dut1 (
    .clk(clk), .reset(reset), .enable(cur_en), .bus(bus1),
    .wr_ptr(o_wp[1]), .irq_half(o_half[1]), .irq_full(o_full[1]),
    .irq_ack(cur_ack), .overrun(o_ov[1])
`ifdef MEMS_MICS_OVERRUN_CNT_EN
    , .overrun_cnt(o_cnt[1])
`endif
  );

  // Behavioural model: index 0 wraps, index 1 is one-shot
  int m_mode [2];
  int m_rr   [2];
  int m_wp   [2];
  int m_acc  [2];
  bit m_wv   [2];
  int m_wa   [2];
  int m_wd   [2];
  bit m_half [2];
  bit m_full [2];
  bit m_ov   [2];
  bit m_ck   [2];
  int m_cnt  [2];
  int m_miss [2][NUM_CH];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic string tg(input int d, input string s);
    return $sformatf("d%0d_%s", d, s);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = M_IDLE; m_rr[d] = 0; m_wp[d] = 0; m_wv[d] = 0;
      m_wa[d] = 0; m_wd[d] = 0; m_half[d] = 0; m_full[d] = 0;
      m_ov[d] = 0; m_ck[d] = 0; m_cnt[d] = 0;
      for (int c = 0; c < NUM_CH; c++) m_miss[d][c] = 0;
    end
  endtask

  task automatic reset_checks(input string ph);
    for (int d = 0; d < 2; d++) begin
      chk(tg(d, {ph, "_ready"}), 32'(o_ready[d]), 0);
      chk(tg(d, {ph, "_wr"}),    32'(o_wr[d]),    0);
      chk(tg(d, {ph, "_cs"}),    32'(o_cs[d]),    0);
      chk(tg(d, {ph, "_clken"}), 32'(o_ck[d]),    0);
      chk(tg(d, {ph, "_addr"}),  32'(o_addr[d]),  0);
      chk(tg(d, {ph, "_data"}),  32'(o_data[d]),  0);
      chk(tg(d, {ph, "_wp"}),    32'(o_wp[d]),    0);
      chk(tg(d, {ph, "_half"}),  32'(o_half[d]),  0);
      chk(tg(d, {ph, "_full"}),  32'(o_full[d]),  0);
      chk(tg(d, {ph, "_ovr"}),   32'(o_ov[d]),    0);
    end
  endtask

  // Compare this cycle's outputs with the model, then advance the model
  task automatic check_and_step();
    bit                act;
    bit                ev;
    int                g;
    int                c;
    logic [NUM_CH-1:0] er;
    for (int d = 0; d < 2; d++) begin
      act = (m_mode[d] == M_RUN) && cur_en;
      g = -1;
      if (act) begin
        for (int i = 0; i < NUM_CH; i++) begin
          c = (m_rr[d] + i) % NUM_CH;
          if (g < 0 && cur_v[c]) g = c;
        end
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk(tg(d, "ready"), 32'(o_ready[d]), 32'(er));
      chk(tg(d, "wr"),    32'(o_wr[d]),    32'(m_wv[d]));
      chk(tg(d, "cs"),    32'(o_cs[d]),    32'(m_wv[d]));
      if (m_wv[d]) begin
        chk(tg(d, "addr"), 32'(o_addr[d]), 32'(m_wa[d]));
        chk(tg(d, "data"), 32'(o_data[d]), 32'(m_wd[d]));
      end
      chk(tg(d, "wp"),    32'(o_wp[d]),   32'(m_wp[d]));
      chk(tg(d, "half"),  32'(o_half[d]), 32'(m_half[d]));
      chk(tg(d, "full"),  32'(o_full[d]), 32'(m_full[d]));
      chk(tg(d, "ovr"),   32'(o_ov[d]),   32'(m_ov[d]));
      chk(tg(d, "clken"), 32'(o_ck[d]),   32'(m_ck[d]));
`ifdef MEMS_MICS_OVERRUN_CNT_EN
      chk(tg(d, "ovcnt"), 32'(o_cnt[d]),  32'(m_cnt[d]));
`endif
      // interrupt flags react to the write shown this cycle
      if (m_wv[d] && m_wa[d] == DEPTH/2 - 1) m_half[d] = 1;
      else if (cur_ack) m_half[d] = 0;
      if (m_wv[d] && m_wa[d] == DEPTH - 1) m_full[d] = 1;
      else if (cur_ack) m_full[d] = 0;
      // overrun: two consecutive lost arbitrations of a valid channel
      ev = 0;
      if (m_mode[d] == M_IDLE && cur_en) begin
        m_ov[d] = 0; m_cnt[d] = 0;
        for (int k = 0; k < NUM_CH; k++) m_miss[d][k] = 0;
      end else begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (act && cur_v[k] && k != g) begin
            m_miss[d][k]++;
            if (m_miss[d][k] == 2) begin ev = 1; m_miss[d][k] = 0; end
          end else m_miss[d][k] = 0;
        end
        if (ev) begin
          m_ov[d] = 1;
          if (m_cnt[d] < 65535) m_cnt[d]++;
        end
      end
      // accepted sample becomes next cycle's RAM write
      m_wv[d] = (g >= 0);
      if (g >= 0) begin
        m_wa[d] = m_wp[d];
        m_wd[d] = int'(cur_data[8*g +: 8]);
        m_wp[d] = (m_wp[d] + 1) % DEPTH;
        m_rr[d] = (g + 1) % NUM_CH;
        m_acc[d]++;
      end
      case (m_mode[d])
        M_IDLE: if (cur_en) begin m_mode[d] = M_RUN; m_wp[d] = 0; end
        M_RUN: begin
          if (!cur_en) m_mode[d] = M_IDLE;
          else if (g >= 0 && m_wa[d] == DEPTH - 1 && d == 1) m_mode[d] = M_DONE;
        end
        default: if (!cur_en) m_mode[d] = M_IDLE;
      endcase
      m_ck[d] = 1;
    end
  endtask

  task automatic tick(input logic en, input logic [NUM_CH-1:0] v,
                      input logic [NUM_CH*8-1:0] data, input logic ack);
    @(negedge clk);
    cur_en = en; cur_v = v; cur_data = data; cur_ack = ack;
    #1;
    check_and_step();
  endtask

  initial begin
    int base;
    int guard;
    logic [NUM_CH*8-1:0] dat;
    m_acc[0] = 0; m_acc[1] = 0;
    model_reset();
    #12;
    reset_checks("rst");
    @(posedge clk); #2 reset = 1'b0;

    // all channels valid: round-robin from channel 0
    tick(1'b1, '0, '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, 4'hF, NUM_CH*8'($urandom), 1'b0);
      chk("rr_seq", 32'(o_ready[0]), 32'(1) << (k % 4));
      if (k > 0) chk("rr_addr", 32'(o_addr[0]), 32'(k - 1));
    end

    // channel 0 alone streams 0..7 into addresses 0..7
    tick(1'b0, '0, '0, 1'b0);
    tick(1'b1, '0, '0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      dat = NUM_CH*8'($urandom);
      dat[7:0] = 8'(k);
      tick(1'b1, 4'b0001, dat, 1'b0);
      chk("ch0_ready", 32'(o_ready[0]), 1);
      if (k > 0) begin
        chk("ch0_addr", 32'(o_addr[0]), 32'(k - 1));
        chk("ch0_data", 32'(o_data[0]), 32'(k - 1));
      end
    end
    // enable drops while the last write is on the bus
    tick(1'b0, 4'b0001, '0, 1'b0);
    chk("late_wr",   32'(o_wr[0]),   1);
    chk("late_addr", 32'(o_addr[0]), 7);
    chk("late_data", 32'(o_data[0]), 7);

    // randomized traffic
    for (int k = 0; k < 1500; k++)
      tick(($urandom % 32) != 0, NUM_CH'($urandom), NUM_CH*8'($urandom), ($urandom % 16) == 0);

    // full buffer pass with ack coinciding with the half-point write
    tick(1'b0, '0, '0, 1'b1);
    tick(1'b0, '0, '0, 1'b0);
    tick(1'b1, '0, '0, 1'b0);
    base = m_acc[0];
    guard = 0;
    while (m_acc[0] - base < DEPTH + 1 && guard < 6000) begin
      tick(1'b1, 4'hF, NUM_CH*8'($urandom), m_wv[1] && m_wa[1] == DEPTH/2 - 1);
      guard++;
    end
    if (guard >= 6000) chk("fill_budget", 32'(m_acc[0] - base), DEPTH + 1);
    tick(1'b1, 4'hF, NUM_CH*8'($urandom), 1'b0);
    chk("wrap_wr",    32'(o_wr[0]),    1);
    chk("wrap_addr",  32'(o_addr[0]),  0);
    chk("wrap_wp",    32'(o_wp[0]),    1);
    chk("done_ready", 32'(o_ready[1]), 0);
    chk("done_half",  32'(o_half[1]),  1);
    chk("done_full",  32'(o_full[1]),  1);

    // asynchronous reset in the middle of a run
    tick(1'b0, '0, '0, 1'b0);
    tick(1'b1, '0, '0, 1'b0);
    guard = 0;
    while (m_wp[0] != 100 && guard < 500) begin
      tick(1'b1, 4'hF, NUM_CH*8'($urandom), 1'b0);
      guard++;
    end
    @(posedge clk); #2;
    chk("pre_rst_wp", 32'(o_wp[0]), 100);
    reset = 1'b1;
    #1;
    reset_checks("midrst");
    model_reset();
    @(posedge clk); #1;
    chk("rst_hold_wr0", 32'(o_wr[0]), 0);
    chk("rst_hold_wr1", 32'(o_wr[1]), 0);
    #1 reset = 1'b0;
    tick(1'b1, '0, '0, 1'b0);
    tick(1'b1, 4'hF, NUM_CH*8'($urandom), 1'b0);
    tick(1'b1, 4'hF, NUM_CH*8'($urandom), 1'b0);
    chk("restart_wr",   32'(o_wr[0]),   1);
    chk("restart_addr", 32'(o_addr[0]), 0);
    for (int k = 0; k < 20; k++)
      tick(1'b1, NUM_CH'($urandom), NUM_CH*8'($urandom), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
